pipe_hazard_ctrl: RTL and testbench

//  Interlock and sequencing controller for the 5-stage F/D/E/M/W datapath.

---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/sequencing controller for the F/D/E/M/W pipeline: RAW scoreboard,
// decode stall with bubble injection, wrong-path squash on M redirect, halt drain.
module pipe_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_writesreg,
  input  logic             dec_halt,
  input  logic             mem_redirect,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic             bubble_e,
  output logic             kill_m,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       h;
  } sbEntry_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  // W is only a hazard source when a same-cycle regfile write is not visible to D.
  localparam int NUM_CHK = WB_BYPASS ? 2 : 3;

  state_t   state, stateNxt;
  sbEntry_t sbE, sbM, sbW;
  sbEntry_t [2:0] sbVec;
  logic [2:0] hit;
  logic       useRs1, useRs2, hz, issue;

  assign sbVec  = {sbW, sbM, sbE};
  assign useRs1 = dec_use_rs1 & (dec_rs1 != 5'd0);
  assign useRs2 = dec_use_rs2 & (dec_rs2 != 5'd0);

  for (genvar i = 0; i < 3; i++) begin : g_chk
    if (i < NUM_CHK) begin : g_on
      assign hit[i] = sbVec[i].v & ((useRs1 & (sbVec[i].rd == dec_rs1)) |
                                    (useRs2 & (sbVec[i].rd == dec_rs2)));
    end else begin : g_off
      assign hit[i] = 1'b0;
    end
  end

  assign hz     = |hit;
  assign issue  = dec_valid & (state == RUN) & ~hz & ~mem_redirect;
  assign halted = (state == HALTED);

  // Control outputs; reset forces every pipeline register to hold/clear.
  always_comb begin
    stall_fd = 1'b0;
    flush_fd = 1'b0;
    bubble_e = 1'b0;
    kill_m   = 1'b0;
    if (!reset) begin
      stall_fd = 1'b1;
      flush_fd = 1'b1;
      bubble_e = 1'b1;
      kill_m   = 1'b1;
    end else if (mem_redirect) begin
      flush_fd = 1'b1;
      bubble_e = 1'b1;
      kill_m   = 1'b1;
    end else if ((state != RUN) || hz) begin
      stall_fd = 1'b1;
      bubble_e = 1'b1;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      RUN:     if (issue && dec_halt) stateNxt = DRAIN;
      DRAIN:   if (mem_redirect)      stateNxt = RUN;
               else if (sbW.h)        stateNxt = HALTED;
      HALTED:  stateNxt = HALTED;
      default: stateNxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      sbE   <= '0;
      sbM   <= '0;
      sbW   <= '0;
    end else begin
      state <= stateNxt;
      sbW   <= sbM;
      sbM   <= kill_m ? sbEntry_t'('0) : sbE;
      sbE   <= issue ? sbEntry_t'{dec_writesreg & (dec_rd != 5'd0), dec_rd, dec_halt}
                     : sbEntry_t'('0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && hz && !mem_redirect && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (no bypass / bypass with a narrow
// counter) driven in lockstep, checked against an in-flight instruction model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dec_valid, dec_use_rs1, dec_use_rs2, dec_writesreg, dec_halt, mem_redirect;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;

  logic stall0, flush0, bub0, kill0, halt0;
  logic stall1, flush1, bub1, kill1, halt1;
  logic [31:0] cnt0;
  logic [2:0]  cnt1;

  pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_writesreg(dec_writesreg), .dec_halt(dec_halt), .mem_redirect(mem_redirect),
    .stall_fd(stall0), .flush_fd(flush0), .bubble_e(bub0), .kill_m(kill0),
    .halted(halt0), .stall_cnt(cnt0));

  pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_writesreg(dec_writesreg), .dec_halt(dec_halt), .mem_redirect(mem_redirect),
    .stall_fd(stall1), .flush_fd(flush1), .bubble_e(bub1), .kill_m(kill1),
    .halted(halt1), .stall_cnt(cnt1));

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the instructions sitting in E, M, W (index 0..2); mode 0=run 1=drain 2=halted.
  typedef struct { bit w; int rd; bit h; } inst_t;
  inst_t   pipe[2][3], npipe[2][3];
  int      mode[2], nmode[2];
  longint  cnt[2], ncnt[2];

  function automatic inst_t mk(bit w, int rd, bit h);
    inst_t x;
    x.w = w; x.rd = rd; x.h = h;
    return x;
  endfunction

  function automatic longint cmax(int k);
    return (k == 1) ? 64'd7 : 64'hFFFF_FFFF;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = mk(0, 0, 0);
      mode[k] = 0;
      cnt[k]  = 0;
    end
  endfunction

  // A source waits for any older writer still ahead of the point where its value becomes readable.
  function automatic bit modelHz(int k);
    int depth;
    depth = (k == 1) ? 2 : 3;
    for (int s = 0; s < depth; s++) begin
      if (pipe[k][s].w &&
          ((dec_use_rs1 && dec_rs1 != 0 && int'(dec_rs1) == pipe[k][s].rd) ||
           (dec_use_rs2 && dec_rs2 != 0 && int'(dec_rs2) == pipe[k][s].rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) modelReset();
    else begin
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 3; s++) pipe[k][s] = npipe[k][s];
        mode[k] = nmode[k];
        cnt[k]  = ncnt[k];
      end
    end
  end

  // Compare process: every cycle, both instances, all outputs.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit hz, redir, iss;
      logic [4:0] exp, act;
      logic [31:0] actCnt;
      hz    = modelHz(k);
      redir = mem_redirect;
      if (!reset)          exp = 5'b11110;
      else if (redir)      exp = {4'b0111, mode[k] == 2};
      else if (mode[k] != 0 || hz) exp = {4'b1010, mode[k] == 2};
      else                 exp = {4'b0000, mode[k] == 2};
      act    = (k == 0) ? {stall0, flush0, bub0, kill0, halt0} : {stall1, flush1, bub1, kill1, halt1};
      actCnt = (k == 0) ? cnt0 : 32'(cnt1);
      check((k == 0) ? "ctl_nobyp" : "ctl_byp", 32'(act), 32'(exp));
      check((k == 0) ? "cnt_nobyp" : "cnt_byp", actCnt, 32'(cnt[k]));

      iss = dec_valid && mode[k] == 0 && !hz && !redir;
      npipe[k][2] = pipe[k][1];
      npipe[k][1] = redir ? mk(0, 0, 0) : pipe[k][0];
      npipe[k][0] = iss ? mk(dec_writesreg && dec_rd != 0, int'(dec_rd), dec_halt) : mk(0, 0, 0);
      nmode[k] = mode[k];
      if (mode[k] == 0 && iss && dec_halt)  nmode[k] = 1;
      else if (mode[k] == 1 && redir)       nmode[k] = 0;
      else if (mode[k] == 1 && pipe[k][2].h) nmode[k] = 2;
      ncnt[k] = cnt[k];
      if (mode[k] == 0 && hz && !redir && cnt[k] < cmax(k)) ncnt[k] = cnt[k] + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit h, bit redir);
    dec_valid = v; dec_rs1 = 5'(rs1); dec_use_rs1 = u1; dec_rs2 = 5'(rs2); dec_use_rs2 = u2;
    dec_rd = 5'(rd); dec_writesreg = w; dec_halt = h; mem_redirect = redir;
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int s0, s1;
    modelReset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_ctl", 32'({stall0, flush0, bub0, kill0, halt0}), 32'h1E);
    check("reset_cnt", cnt0, 32'd0);
    step();
    reset = 1'b1;

    // RAW on x5: 3 stalls without bypass, 2 with.
    step(); drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(); drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
    s0 = 0; s1 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s0 += int'(stall0);
      s1 += int'(stall1);
    end
    check("raw_stalls_nobyp", 32'(s0), 32'd3);
    check("raw_stalls_byp", 32'(s1), 32'd2);
    step(); idle(0);
    @(negedge clk);
    check("raw_cnt_nobyp", cnt0, 32'd3);
    check("raw_cnt_byp", 32'(cnt1), 32'd2);

    // x0 never hazards; a non-writing producer never matches.
    step(); drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(); drive(1, 0, 1, 0, 1, 8, 1, 0, 0);
    @(negedge clk); check("x0_nostall", 32'(stall0), 32'd0);
    step(); drive(1, 1, 1, 2, 1, 7, 0, 0, 0);
    step(); drive(1, 7, 1, 0, 0, 9, 1, 0, 0);
    @(negedge clk); check("store_nostall", 32'(stall0), 32'd0);

    // Jump, addi x7, reader of x7 with redirect.
    step(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
    step(); drive(1, 7, 1, 0, 0, 10, 1, 0, 1);
    @(negedge clk);
    check("redir_ctl", 32'({stall0, flush0, bub0, kill0}), 32'h7);
    step(); drive(1, 7, 1, 0, 0, 10, 1, 0, 0);
    @(negedge clk); check("post_redir_nostall", 32'(stall0), 32'd0);

    // Hazard and redirect together: redirect wins, counter frozen.
    step(); drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(); drive(1, 5, 1, 0, 0, 11, 1, 0, 1);
    @(negedge clk);
    check("hz_redir_stall", 32'(stall0), 32'd0);
    check("hz_redir_flush", 32'(flush0), 32'd1);
    step(); idle(0);
    @(negedge clk); check("hz_redir_cnt", cnt0, 32'd3);

    // Halt drain.
    idle(4);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(); idle(0);
    @(negedge clk);
    check("halt_e0", 32'({stall0, halt0}), 32'h2);
    step(); @(negedge clk); check("halt_e1", 32'(halt0), 32'd0);
    step(); @(negedge clk); check("halt_e2", 32'(halt0), 32'd0);
    step(); @(negedge clk); check("halt_e3", 32'({halt0, halt1}), 32'h3);
    step(); mem_redirect = 1'b1;
    @(negedge clk); check("halted_redir", 32'({halt0, flush0}), 32'h3);
    step(); mem_redirect = 1'b0;
    step(); @(negedge clk); check("halted_sticky", 32'(halt0), 32'd1);

    // Reset asserted between edges mid-drain.
    step(); reset = 1'b0;
    step(); reset = 1'b1;
    idle(2);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(); idle(0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_ctl0", 32'({stall0, flush0, bub0, kill0, halt0}), 32'h1E);
    check("async_rst_ctl1", 32'({stall1, flush1, bub1, kill1, halt1}), 32'h1E);
    step(); step(); reset = 1'b1;
    @(negedge clk);
    check("after_rst_cnt", cnt0 | 32'(cnt1), 32'd0);
    step(); drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    step(); drive(1, 9, 1, 0, 0, 12, 1, 0, 0);
    @(negedge clk); check("first_issue", 32'(stall0), 32'd1);

    // Halt killed by an older jump's redirect: back to RUN.
    idle(5);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check("halt_kill_flush", 32'(flush0), 32'd1);
    step(); idle(0);
    @(negedge clk); check("halt_killed_run", 32'({halt0, stall0}), 32'h0);
    idle(3);
    @(negedge clk); check("halt_killed_stay", 32'(halt0), 32'd0);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      step();
      if ((mode[0] == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        reset = 1'b0;
      else
        reset = 1'b1;
      dec_valid     = 1'($urandom_range(0, 1));
      dec_rs1       = 5'($urandom_range(0, 3));
      dec_rs2       = 5'($urandom_range(0, 3));
      dec_use_rs1   = 1'($urandom_range(0, 1));
      dec_use_rs2   = 1'($urandom_range(0, 1));
      dec_rd        = 5'($urandom_range(0, 3));
      dec_writesreg = 1'($urandom_range(0, 1));
      dec_halt      = ($urandom_range(0, 39) == 0);
      mem_redirect  = ($urandom_range(0, 9) == 0);
    end
    step(); reset = 1'b1; idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
